cpu5_lsu: RTL and testbench
===========================

// Module: cpu5_lsu
// PURPOSE
//  Load/store unit directly downstream of the cpu5 datapath: consumes dataaddr/writedata
//  plus the LW/SW-class funct3 and turns them into a valid/ready data-memory transaction.
//  Generates byte strobes, extracts and sign/zero-extends load data into readdata, and
//  stalls the core (lsu_stall) until each access completes. Memory may insert any number
//  of wait states on both the request and the response.
// PARAMETERS
//  XLEN     32   data/address width; only 32 is supported
//  STRB_W   4    byte strobes, XLEN/8
// PORTS
//  clk            in   1      core clock, rising edge
//  reset          in   1      synchronous, active-low reset
//  lsu_valid      in   1      access requested; held high until lsu_done
//  lsu_we         in   1      1 = store, 0 = load
//  lsu_funct3     in   3      000 B, 001 H, 010 W, 100 BU, 101 HU
//  lsu_addr       in   XLEN   byte address (datapath dataaddr)
//  lsu_wdata      in   XLEN   store data, LSB-aligned (datapath writedata)
//  lsu_stall      out  1      freeze PC/pipeline
//  lsu_done       out  1      one-cycle completion pulse
//  lsu_rdata      out  XLEN   extended load result (datapath readdata)
//  lsu_misalign   out  1      one-cycle misaligned-access pulse (feature-gated)
//  mem_req_valid  out  1      request valid
//  mem_req_ready  in   1      memory accepts request
//  mem_req_we     out  1      write enable
//  mem_req_addr   out  XLEN   word address, bits [1:0] = 0
//  mem_req_wstrb  out  4      byte enables
//  mem_req_wdata  out  XLEN   store data shifted to byte lane
//  mem_rsp_valid  in   1      load data valid (one cycle per load)
//  mem_rsp_rdata  in   XLEN   raw word read
// BEHAVIOUR
//  - Reset (reset==0 at clk edge): state IDLE; all outputs 0, lsu_rdata 0.
//  - FSM IDLE -> REQ -> (store) IDLE | (load) RESP -> IDLE.
//  - IDLE: lsu_valid & !lsu_done -> capture we/funct3/addr/wdata into registers -> REQ.
//  - REQ: mem_req_valid=1, all mem_req_* from captured regs and stable until accept.
//    valid & ready: store -> IDLE, lsu_done=1 next cycle; load -> RESP.
//  - RESP: mem_req_valid=0; on mem_rsp_valid register extended data into lsu_rdata,
//    lsu_done=1 next cycle, -> IDLE. mem_rsp_valid outside RESP is ignored.
//  - lsu_done is registered, high exactly one cycle; lsu_valid seen in the done cycle is
//    ignored (new access starts the following cycle).
//  - lsu_stall = lsu_valid & !lsu_done (combinational).
//  - Min latency, valid to done: store 2 cycles (ready=1), load 3 cycles (rsp next cycle).
//  - lsu_rdata holds its value until the next load completes.
//  - Strobes: B 0001<<a[1:0]; H 0011<<{a[1],0}; W 1111. wdata = B replicated x4, H x2, W.
//  - Load extract: byte lane a[1:0] / half lane a[1]; B,H sign-extend; BU,HU zero-extend.
//  - Unsupported funct3 (011,110,111): treated as W.
//  - reset low mid-transaction: FSM to IDLE immediately; outstanding response dropped.
// CONFIGURATION
//  CPU5_LSU_MISALIGN_EN defined: H with a[0]=1 or W with a[1:0]!=0 in IDLE -> no memory
//    request; lsu_misalign and lsu_done pulse together the next cycle; lsu_rdata unchanged.
//  Not defined: lsu_misalign tied 0; low address bits ignored for lane selection beyond
//    the rules above (H uses a[1], W uses none); access proceeds normally.
// TESTING
//  1 LW addr 0x100, ready=1, rsp next cycle rdata 0xDEADBEEF -> req addr 0x100 strb 1111,
//    done 3 cycles after valid, lsu_rdata 0xDEADBEEF.
//  2 LB addr 0x103, rdata 0x80112233 -> lsu_rdata 0xFFFFFF80; LBU same -> 0x00000080.
//  3 SB addr 0x202 wdata 0x000000A5 -> strb 0100, wdata 0xA5A5A5A5, we=1, done 2 cycles.
//  4 SH addr 0x10 with ready low 5 cycles -> req_* stable 5 cycles, stall high until done.
//  5 MISALIGN_EN: LW addr 0x101 -> no mem_req_valid, misalign+done pulse 1 cycle later.
//  6 reset low while in RESP, then rsp arrives -> ignored, outputs 0, next LW normal.

Source files
------------

// File: rtl/cpu5_lsu.sv
// Load/store unit: turns a held datapath access into a valid/ready memory transaction.
// Optional misaligned-access trap enabled by defining CPU5_LSU_MISALIGN_EN.
module cpu5_lsu #(
  parameter int XLEN   = 32,
  parameter int STRB_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lsu_valid,
  input  logic              lsu_we,
  input  logic [2:0]        lsu_funct3,
  input  logic [XLEN-1:0]   lsu_addr,
  input  logic [XLEN-1:0]   lsu_wdata,
  output logic              lsu_stall,
  output logic              lsu_done,
  output logic [XLEN-1:0]   lsu_rdata,
  output logic              lsu_misalign,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic [STRB_W-1:0] mem_req_wstrb,
  output logic [XLEN-1:0]   mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_rdata
);

  // state  | meaning
  // S_IDLE | waiting for a new access, captures request fields
  // S_REQ  | presenting the captured request until memory accepts it
  // S_RESP | load accepted, waiting for the read response
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [XLEN-1:0]     addr_q, addr_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic                done_q, done_d;
  logic                misalign_q, misalign_d;
  logic [XLEN-1:0]     rdata_q, rdata_d;

  logic                is_byte;
  logic                is_half;
  logic [STRB_W-1:0]   strb_new;
  logic [XLEN-1:0]     wdata_new;
  logic                misalign_new;
  logic [7:0]          rsp_byte;
  logic [15:0]         rsp_half;
  logic [XLEN-1:0]     load_ext;

  // Unsupported size encodings fall through to word accesses.
  assign is_byte = (lsu_funct3[1:0] == 2'b00);
  assign is_half = (lsu_funct3[1:0] == 2'b01);

  always_comb begin
    strb_new  = 4'b1111;
    wdata_new = lsu_wdata;
    if (is_byte) begin
      wdata_new = {4{lsu_wdata[7:0]}};
      case (lsu_addr[1:0])
        2'b00:   strb_new = 4'b0001;
        2'b01:   strb_new = 4'b0010;
        2'b10:   strb_new = 4'b0100;
        default: strb_new = 4'b1000;
      endcase
    end else if (is_half) begin
      wdata_new = {2{lsu_wdata[15:0]}};
      strb_new  = lsu_addr[1] ? 4'b1100 : 4'b0011;
    end
  end

`ifdef CPU5_LSU_MISALIGN_EN
  assign misalign_new = (is_half & lsu_addr[0]) |
                        (!is_byte & !is_half & (lsu_addr[1:0] != 2'b00));
`else
  assign misalign_new = 1'b0;
`endif

  always_comb begin
    case (addr_q[1:0])
      2'b00:   rsp_byte = mem_rsp_rdata[7:0];
      2'b01:   rsp_byte = mem_rsp_rdata[15:8];
      2'b10:   rsp_byte = mem_rsp_rdata[23:16];
      default: rsp_byte = mem_rsp_rdata[31:24];
    endcase
    rsp_half = addr_q[1] ? mem_rsp_rdata[31:16] : mem_rsp_rdata[15:0];
  end

  always_comb begin
    case (funct3_q)
      3'b000:  load_ext = {{24{rsp_byte[7]}}, rsp_byte};
      3'b100:  load_ext = {24'd0, rsp_byte};
      3'b001:  load_ext = {{16{rsp_half[15]}}, rsp_half};
      3'b101:  load_ext = {16'd0, rsp_half};
      default: load_ext = mem_rsp_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wstrb_d    = wstrb_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    done_d     = 1'b0;
    misalign_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        // done_q gates off the still-high valid of the access just completed
        if (lsu_valid && !done_q) begin
          we_d     = lsu_we;
          funct3_d = lsu_funct3;
          addr_d   = lsu_addr;
          wstrb_d  = strb_new;
          wdata_d  = wdata_new;
          if (misalign_new) begin
            done_d     = 1'b1;
            misalign_d = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          if (we_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (mem_rsp_valid) begin
          rdata_d = load_ext;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      funct3_q   <= 3'd0;
      addr_q     <= '0;
      wstrb_q    <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wstrb_q    <= wstrb_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      misalign_q <= misalign_d;
      rdata_q    <= rdata_d;
    end
  end

  assign lsu_stall     = lsu_valid & ~done_q;
  assign lsu_done      = done_q;
  assign lsu_rdata     = rdata_q;
  assign lsu_misalign  = misalign_q;
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_we    = we_q;
  assign mem_req_addr  = {addr_q[XLEN-1:2], 2'b00};
  assign mem_req_wstrb = wstrb_q;
  assign mem_req_wdata = wdata_q;

endmodule

// File: tb/tb_cpu5_lsu.sv
// Scoreboard bench for cpu5_lsu: byte-level memory reference model, randomized
// accesses, wait states on request and response, plus reset-abort scenario.
module tb_cpu5_lsu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        lsu_valid = 1'b0;
  logic        lsu_we = 1'b0;
  logic [2:0]  lsu_funct3 = 3'd0;
  logic [31:0] lsu_addr = 32'd0;
  logic [31:0] lsu_wdata = 32'd0;
  logic        lsu_stall, lsu_done, lsu_misalign;
  logic [31:0] lsu_rdata;
  logic        mem_req_valid, mem_req_we;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_rdata = 32'd0;

  cpu5_lsu dut (
    .clk(clk), .reset(reset),
    .lsu_valid(lsu_valid), .lsu_we(lsu_we), .lsu_funct3(lsu_funct3),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_stall(lsu_stall), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
    .lsu_misalign(lsu_misalign),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wstrb(mem_req_wstrb), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
  } done_t;

  int checks = 0;
  int errors = 0;

  req_t  exp_req[$];
  done_t exp_done[$];
  logic [7:0]  refm [bit [31:0]];
  logic [31:0] wmem [bit [31:0]];
  logic [31:0] last_rdata = 32'd0;

  // responder controls
  bit  fast = 1'b1;
  int  rsp_override = -1;
  int  ready_hold = 0;
  bit  pend = 1'b0;
  int  dly = 0;
  logic [31:0] paddr = 32'd0;

  // monitor state
  logic        acc_v = 1'b0, acc_we = 1'b0;
  logic [31:0] acc_addr = 32'd0, acc_wdata = 32'd0;
  logic [3:0]  acc_strb = 4'd0;
  logic [3:0]  last_strb = 4'd0;
  logic [31:0] last_wdata = 32'd0;
  logic        last_we = 1'b0;
  int          req_seen = 0;
  logic        prev_hold = 1'b0, prev_done = 1'b0;
  req_t        prev_req;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] wa);
    return (wa * 32'h9E3779B1) ^ 32'h5A5AA5A5;
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] wa);
    if (wmem.exists(wa)) return wmem[wa];
    return init_word(wa);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    logic [31:0] w;
    if (refm.exists(a)) return refm[a];
    w = init_word({a[31:2], 2'b00}) >> (8 * int'(a[1:0]));
    return w[7:0];
  endfunction

  task automatic preload(input logic [31:0] wa, input logic [31:0] word);
    wmem[wa] = word;
    for (int i = 0; i < 4; i++) refm[wa + i] = word[8*i +: 8];
  endtask

  // Memory side: ready wait states, store write-back, load response with delay.
  initial begin
    logic [31:0] w;
    forever begin
      @(posedge clk);
      #1;
      if (acc_v) begin
        if (acc_we) begin
          w = rd_word(acc_addr);
          for (int k = 0; k < 4; k++)
            if (acc_strb[k]) w[8*k +: 8] = acc_wdata[8*k +: 8];
          wmem[acc_addr] = w;
        end else begin
          pend  = 1'b1;
          dly   = (rsp_override >= 0) ? rsp_override : (fast ? 0 : int'($urandom_range(0, 3)));
          paddr = acc_addr;
        end
      end
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = $urandom;
      if (pend) begin
        if (dly == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_rdata = rd_word(paddr);
          pend = 1'b0;
        end else begin
          dly--;
        end
      end else if (!fast && $urandom_range(0, 7) == 0) begin
        mem_rsp_valid = 1'b1;
      end
      if (ready_hold > 0) begin
        mem_req_ready = 1'b0;
        if (mem_req_valid) ready_hold--;
      end else begin
        mem_req_ready = fast ? 1'b1 : ($urandom_range(0, 2) != 0);
      end
    end
  end

  // Monitor: pops expectations when the DUT presents a request or a completion.
  always @(negedge clk) begin
    acc_v     = mem_req_valid & mem_req_ready & reset;
    acc_we    = mem_req_we;
    acc_addr  = mem_req_addr;
    acc_strb  = mem_req_wstrb;
    acc_wdata = mem_req_wdata;
    if (mem_req_valid) req_seen++;
    if (prev_hold) begin
      chk("req_hold_valid", {31'd0, mem_req_valid}, 32'd1);
      chk("req_hold_addr", mem_req_addr, prev_req.addr);
      chk("req_hold_strb", {28'd0, mem_req_wstrb}, {28'd0, prev_req.strb});
      chk("req_hold_wdata", mem_req_wdata, prev_req.wdata);
    end
    prev_hold      = mem_req_valid & ~mem_req_ready & reset;
    prev_req.we    = mem_req_we;
    prev_req.addr  = mem_req_addr;
    prev_req.strb  = mem_req_wstrb;
    prev_req.wdata = mem_req_wdata;
    if (acc_v) begin
      last_strb = mem_req_wstrb; last_wdata = mem_req_wdata; last_we = mem_req_we;
      if (exp_req.size() == 0) begin
        chk("unexpected_req", 32'd1, 32'd0);
      end else begin
        req_t r;
        r = exp_req.pop_front();
        chk("req_we", {31'd0, mem_req_we}, {31'd0, r.we});
        chk("req_addr", mem_req_addr, r.addr);
        chk("req_strb", {28'd0, mem_req_wstrb}, {28'd0, r.strb});
        if (r.we) chk("req_wdata", mem_req_wdata, r.wdata);
      end
    end
    if (lsu_done) begin
      chk("done_one_cycle", {31'd0, prev_done}, 32'd0);
      if (exp_done.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        done_t d;
        d = exp_done.pop_front();
        chk("rdata", lsu_rdata, d.rdata);
        chk("misalign", {31'd0, lsu_misalign}, {31'd0, d.mis});
      end
    end else begin
      chk("misalign_idle", {31'd0, lsu_misalign}, 32'd0);
    end
    prev_done = lsu_done;
  end

  // Issues one access (called at posedge+1), records expectations, waits for done.
  task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output int cyc);
    int          sz, off;
    bit          mis;
    logic [31:0] base, v;
    req_t        r;
    done_t       d;
    sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
`ifdef CPU5_LSU_MISALIGN_EN
    mis = (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    base = (sz == 1) ? a : (sz == 2) ? {a[31:1], 1'b0} : {a[31:2], 2'b00};
    off  = int'(base[1:0]);
    if (!mis) begin
      r.we = we; r.addr = {a[31:2], 2'b00}; r.strb = 4'd0; r.wdata = 32'd0;
      for (int i = 0; i < sz; i++) r.strb[off + i] = 1'b1;
      for (int k = 0; k < 4; k++) r.wdata[8*k +: 8] = wd[8*(k % sz) +: 8];
      exp_req.push_back(r);
      if (we) begin
        for (int i = 0; i < sz; i++) refm[base + i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < sz; i++) v = v | ({24'd0, ref_rd(base + i)} << (8 * i));
        if (sz == 1) v = f3[2] ? {24'd0, v[7:0]} : {{24{v[7]}}, v[7:0]};
        if (sz == 2) v = f3[2] ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
        last_rdata = v;
      end
    end
    d.rdata = last_rdata;
    d.mis   = mis;
    exp_done.push_back(d);
    lsu_valid = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = a; lsu_wdata = wd;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (lsu_done) break;
      chk("stall_busy", {31'd0, lsu_stall}, 32'd1);
      cyc++;
      if (cyc > 100) begin
        chk("done_timeout", 32'd0, 32'd1);
        break;
      end
    end
    if (lsu_done) chk("stall_done", {31'd0, lsu_stall}, 32'd0);
    @(posedge clk);
    #1;
    lsu_valid = 1'b0;
    lsu_we    = $urandom_range(0, 1);
    lsu_addr  = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=hang required=finish");
    $fatal(1);
  end

  initial begin
    int cyc, seen0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_done", {31'd0, lsu_done}, 32'd0);
    chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_rdata", lsu_rdata, 32'd0);
    chk("rst_stall", {31'd0, lsu_stall}, 32'd0);
    chk("rst_req_addr", mem_req_addr, 32'd0);
    chk("rst_req_strb", {28'd0, mem_req_wstrb}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(2);

    fast = 1'b1;
    preload(32'h100, 32'hDEADBEEF);
    do_access(1'b0, 3'b010, 32'h100, 32'd0, cyc);
    chk("t1_latency", cyc, 32'd3);
    chk("t1_rdata", lsu_rdata, 32'hDEADBEEF);
    chk("t1_strb", {28'd0, last_strb}, 32'h0000000F);

    preload(32'h100, 32'h80112233);
    do_access(1'b0, 3'b000, 32'h103, 32'd0, cyc);
    chk("t2_lb", lsu_rdata, 32'hFFFFFF80);
    do_access(1'b0, 3'b100, 32'h103, 32'd0, cyc);
    chk("t2_lbu", lsu_rdata, 32'h00000080);

    do_access(1'b1, 3'b000, 32'h202, 32'h000000A5, cyc);
    chk("t3_latency", cyc, 32'd2);
    chk("t3_strb", {28'd0, last_strb}, 32'h00000004);
    chk("t3_wdata", last_wdata, 32'hA5A5A5A5);
    chk("t3_we", {31'd0, last_we}, 32'd1);
    chk("t3_rdata_hold", lsu_rdata, 32'h00000080);

    ready_hold = 5;
    do_access(1'b1, 3'b001, 32'h10, 32'h00001234, cyc);
    chk("t4_latency", cyc, 32'd7);

`ifdef CPU5_LSU_MISALIGN_EN
    seen0 = req_seen;
    do_access(1'b0, 3'b010, 32'h101, 32'd0, cyc);
    chk("t5_latency", cyc, 32'd1);
    chk("t5_no_req", req_seen - seen0, 32'd0);
    chk("t5_rdata_hold", lsu_rdata, 32'h00000080);
`else
    seen0 = req_seen;
    do_access(1'b0, 3'b010, 32'h101, 32'd0, cyc);
    chk("t5_latency", cyc, 32'd3);
    chk("t5_req_made", {31'd0, (req_seen - seen0) > 0}, 32'd1);
`endif

    // Abort a load in RESP with reset; its late response must be dropped.
    rsp_override = 4;
    begin
      req_t r;
      r.we = 1'b0; r.addr = 32'h100; r.strb = 4'hF; r.wdata = 32'd0;
      exp_req.push_back(r);
    end
    lsu_valid = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h100;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(mem_req_valid && mem_req_ready) && cyc < 50);
    chk("t6_accept_seen", {31'd0, cyc < 50}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    lsu_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("t6_done", {31'd0, lsu_done}, 32'd0);
      chk("t6_req_valid", {31'd0, mem_req_valid}, 32'd0);
      chk("t6_rdata", lsu_rdata, 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_override = -1;
    last_rdata = 32'd0;
    do_access(1'b0, 3'b010, 32'h100, 32'd0, cyc);
    chk("t6_next_lw", lsu_rdata, 32'h80112233);
    chk("t6_latency", cyc, 32'd3);

    fast = 1'b0;
    for (int n = 0; n < 300; n++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      f3 = 3'($urandom_range(0, 7));
      a  = 32'h1000 + 32'($urandom_range(0, 47));
      do_access(1'($urandom_range(0, 1)), f3, a, $urandom, cyc);
      idle($urandom_range(0, 2));
    end

    fast = 1'b1;
    idle(10);
    chk("req_queue_empty", exp_req.size(), 32'd0);
    chk("done_queue_empty", exp_done.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
